// File: rtl/lfsr_prng_gen_pkg.sv
// Shared constants for the LFSR pseudo-random generator.
//   MODE_FIB / MODE_GAL : values for the GALOIS parameter of lfsr_prng_gen
//   TAPS(width)         : maximal-length feedback mask for widths 4..32,
//                         bit (t-1) set for every polynomial tap t.
//                         Returns 0 for an unsupported width.
package lfsr_prng_gen_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  function automatic logic [31:0] TAPS(input int width);
    logic [31:0] mask;
    mask = 32'h0;
    case (width)
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_B400;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = 32'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_gen_if.sv
// Sample stream between the generator and its consumer.
//   prng_out  : registered sample                     (generator -> consumer)
//   out_valid : prng_out holds an unconsumed sample   (generator -> consumer)
//   wrap      : 1-cycle pulse, sample equals the start reference
//   out_ready : consumer takes the sample when out_valid && out_ready
// master = generator side, slave = consumer side.
interface lfsr_prng_gen_if
  import lfsr_prng_gen_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] prng_out;
  logic             out_valid;
  logic             out_ready;
  logic             wrap;

  modport master (
    output prng_out,
    output out_valid,
    output wrap,
    input  out_ready
  );

  modport slave (
    input  prng_out,
    input  out_valid,
    input  wrap,
    output out_ready
  );

endinterface

// File: rtl/lfsr_prng_gen_tick_div.sv
// Clock-enable divider: tick is high for one clk cycle out of every DIV.
//   clk  : clock
//   rst  : asynchronous active-high reset, counter -> 0
//   clr  : synchronous restart of the count at 0
//   tick : high while the counter sits at DIV-1 (always high for DIV = 1)
module tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_prng_gen.sv
// Parametrised LFSR pseudo-random generator with a valid/ready sample slot.
//   clk          : clock (all logic on this clock, stepping via clock enable)
//   rst          : asynchronous active-high reset
//   en_i         : free-run, advance on every divider tick
//   step_req_i   : single-step request, honoured only while en_i = 0
//   seed_load_i  : load seed_in_i (zero replaced by SEED) into LFSR and reference
//   seed_in_i    : seed value
//   clr_flags_i  : clear overrun_o and seed_err_o (a same-cycle set wins)
//   overrun_o    : sticky, an advance was dropped because the slot was full
//   seed_err_o   : sticky, seed_load_i seen with seed_in_i == 0
//   stream       : sample stream (prng_out, out_valid, wrap / out_ready)
// Parameters: WIDTH 4..32, DIV 1..2^26, SEED non-zero,
//             GALOIS = MODE_FIB (left shift) or MODE_GAL (right shift).
module lfsr_prng_gen
  import lfsr_prng_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV    = 1,
  parameter int SEED   = 1,
  parameter int GALOIS = MODE_FIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             step_req_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic             clr_flags_i,
  output logic             overrun_o,
  output logic             seed_err_o,
  lfsr_prng_gen_if.master  stream
);

  localparam logic [WIDTH-1:0] MASK   = WIDTH'(TAPS(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             overrun_q, overrun_d;
  logic             seed_err_q, seed_err_d;

  logic             tick;
  logic             req;
  logic             free;
  logic             advance;
  logic             drop;
  logic             seed_zero;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] nxt;

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (seed_load_i),
    .tick (tick)
  );

  // Free-run steps on ticks; single steps bypass the divider.
  assign req     = (en_i & tick) | (~en_i & step_req_i);
  // The slot can take a new sample if empty or being drained this cycle.
  assign free    = ~valid_q | stream.out_ready;
  assign advance = req & free & ~seed_load_i;
  assign drop    = req & ~free & ~seed_load_i;

  // A zero seed would lock the register; substitute the reset seed.
  assign seed_zero = (seed_in_i == '0);
  assign seed_eff  = seed_zero ? SEED_W : seed_in_i;

  generate
    if (GALOIS == MODE_GAL) begin : g_galois
      assign nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : '0);
    end else begin : g_fibonacci
      assign nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & MASK)};
    end
  endgenerate

  always_comb begin
    lfsr_d     = lfsr_q;
    ref_d      = ref_q;
    out_d      = out_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    overrun_d  = overrun_q;
    seed_err_d = seed_err_q;

    // Clear first so that a set later in this block takes precedence.
    if (clr_flags_i) begin
      overrun_d  = 1'b0;
      seed_err_d = 1'b0;
    end

    if (advance) begin
      lfsr_d  = nxt;
      out_d   = nxt;
      valid_d = 1'b1;
      wrap_d  = (nxt == ref_q);
    end else begin
      // Consumer drained the slot and nothing replaces the sample.
      if (valid_q && stream.out_ready) begin
        valid_d = 1'b0;
      end
      if (seed_load_i) begin
        lfsr_d = seed_eff;
        ref_d  = seed_eff;
        if (seed_zero) begin
          seed_err_d = 1'b1;
        end
      end
      if (drop) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q     <= SEED_W;
      ref_q      <= SEED_W;
      out_q      <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      overrun_q  <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      ref_q      <= ref_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      overrun_q  <= overrun_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign stream.prng_out  = out_q;
  assign stream.out_valid = valid_q;
  assign stream.wrap      = wrap_q;
  assign overrun_o        = overrun_q;
  assign seed_err_o       = seed_err_q;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed bench for lfsr_prng_gen. Four instances share one stimulus set:
//   u_f4 : WIDTH 4, Fibonacci, DIV 1
//   u_g4 : WIDTH 4, Galois,    DIV 1
//   u_f8 : WIDTH 8, Fibonacci, DIV 1
//   u_d3 : WIDTH 4, Fibonacci, DIV 3
// Each scenario task resets everything first and checks only the instance(s)
// it is about. Inputs change and outputs are sampled 1 ns after posedge.
module tb_lfsr_prng_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       step_req;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       clr_flags;
  logic       out_ready;

  logic ov_f4, se_f4, ov_g4, se_g4, ov_f8, se_f8, ov_d3, se_d3;

  int checks   = 0;
  int failures = 0;

  lfsr_prng_gen_if #(.WIDTH(4)) if_f4 ();
  lfsr_prng_gen_if #(.WIDTH(4)) if_g4 ();
  lfsr_prng_gen_if #(.WIDTH(8)) if_f8 ();
  lfsr_prng_gen_if #(.WIDTH(4)) if_d3 ();

  assign if_f4.out_ready = out_ready;
  assign if_g4.out_ready = out_ready;
  assign if_f8.out_ready = out_ready;
  assign if_d3.out_ready = out_ready;

  // Hand-derived sample sequences starting from seed 1.
  logic [3:0] fib4_seq [0:14] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] gal4_seq [0:14] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                  4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

  always #5 clk = ~clk;

  lfsr_prng_gen #(.WIDTH(4), .DIV(1), .SEED(1), .GALOIS(0)) u_f4 (
    .clk(clk), .rst(rst), .en_i(en), .step_req_i(step_req), .seed_load_i(seed_load),
    .seed_in_i(seed_in[3:0]), .clr_flags_i(clr_flags), .overrun_o(ov_f4),
    .seed_err_o(se_f4), .stream(if_f4));

  lfsr_prng_gen #(.WIDTH(4), .DIV(1), .SEED(1), .GALOIS(1)) u_g4 (
    .clk(clk), .rst(rst), .en_i(en), .step_req_i(step_req), .seed_load_i(seed_load),
    .seed_in_i(seed_in[3:0]), .clr_flags_i(clr_flags), .overrun_o(ov_g4),
    .seed_err_o(se_g4), .stream(if_g4));

  lfsr_prng_gen #(.WIDTH(8), .DIV(1), .SEED(1), .GALOIS(0)) u_f8 (
    .clk(clk), .rst(rst), .en_i(en), .step_req_i(step_req), .seed_load_i(seed_load),
    .seed_in_i(seed_in), .clr_flags_i(clr_flags), .overrun_o(ov_f8),
    .seed_err_o(se_f8), .stream(if_f8));

  lfsr_prng_gen #(.WIDTH(4), .DIV(3), .SEED(1), .GALOIS(0)) u_d3 (
    .clk(clk), .rst(rst), .en_i(en), .step_req_i(step_req), .seed_load_i(seed_load),
    .seed_in_i(seed_in[3:0]), .clr_flags_i(clr_flags), .overrun_o(ov_d3),
    .seed_err_o(se_d3), .stream(if_d3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    en        = 1'b0;
    step_req  = 1'b0;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    clr_flags = 1'b0;
    out_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (if_f4.prng_out !== 4'h0 || if_f4.out_valid !== 1'b0 || if_f4.wrap !== 1'b0 ||
        ov_f4 !== 1'b0 || se_f4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%h valid=%b wrap=%b ov=%b se=%b required 0/0/0/0/0",
               if_f4.prng_out, if_f4.out_valid, if_f4.wrap, ov_f4, se_f4);
    end
    // Fill the slot and raise overrun, then reset in the middle of a cycle.
    en = 1'b1;
    out_ready = 1'b0;
    repeat (3) cyc();
    checks++;
    if (ov_f4 !== 1'b1 || if_f4.out_valid !== 1'b1 || if_f4.prng_out !== 4'h2) begin
      failures++;
      $display("FAIL reset_prefill ov=%b valid=%b out=%h required 1/1/2",
               ov_f4, if_f4.out_valid, if_f4.prng_out);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (if_f4.prng_out !== 4'h0 || if_f4.out_valid !== 1'b0 || ov_f4 !== 1'b0 ||
        se_f4 !== 1'b0 || if_f4.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_async out=%h valid=%b ov=%b se=%b wrap=%b required all 0",
               if_f4.prng_out, if_f4.out_valid, ov_f4, se_f4, if_f4.wrap);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    checks++;
    if (if_f4.prng_out !== 4'h2 || if_f4.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_step out=%h valid=%b required 2/1",
               if_f4.prng_out, if_f4.out_valid);
    end
    $display("test_reset: done");
  endtask

  task automatic test_fib4();
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      checks++;
      if (if_f4.prng_out !== fib4_seq[i % 15] || if_f4.out_valid !== 1'b1 ||
          if_f4.wrap !== ((i % 15) == 14)) begin
        failures++;
        $display("FAIL fib4 sample %0d out=%h valid=%b wrap=%b required %h/1/%b",
                 i, if_f4.prng_out, if_f4.out_valid, if_f4.wrap,
                 fib4_seq[i % 15], ((i % 15) == 14));
      end
      $display("fib4 sample %0d out=%h wrap=%b", i, if_f4.prng_out, if_f4.wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_gal4();
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++;
      if (if_g4.prng_out !== gal4_seq[i % 15] || if_g4.wrap !== ((i % 15) == 14)) begin
        failures++;
        $display("FAIL gal4 sample %0d out=%h wrap=%b required %h/%b",
                 i, if_g4.prng_out, if_g4.wrap, gal4_seq[i % 15], ((i % 15) == 14));
      end
      $display("gal4 sample %0d out=%h wrap=%b", i, if_g4.prng_out, if_g4.wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_fib8_period();
    int wraps;
    wraps = 0;
    apply_reset();
    en = 1'b1;
    for (int i = 1; i <= 510; i++) begin
      cyc();
      if (if_f8.wrap === 1'b1) wraps++;
      checks++;
      if (if_f8.wrap !== ((i % 255) == 0)) begin
        failures++;
        $display("FAIL fib8_wrap sample %0d wrap=%b required %b", i, if_f8.wrap, ((i % 255) == 0));
      end
      if (i == 1) begin
        checks++;
        if (if_f8.prng_out !== 8'h02) begin
          failures++;
          $display("FAIL fib8_first out=%h required 02", if_f8.prng_out);
        end
      end
      if (i == 255) begin
        checks++;
        if (if_f8.prng_out !== 8'h01) begin
          failures++;
          $display("FAIL fib8_period_end out=%h required 01", if_f8.prng_out);
        end
      end
    end
    en = 1'b0;
    $display("fib8 period: %0d wrap pulses in 510 samples", wraps);
  endtask

  task automatic test_div3();
    apply_reset();
    en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      checks++;
      if (if_d3.out_valid !== ((c % 3) == 0)) begin
        failures++;
        $display("FAIL div3_valid cycle %0d valid=%b required %b", c, if_d3.out_valid, ((c % 3) == 0));
      end
      if ((c % 3) == 0) begin
        checks++;
        if (if_d3.prng_out !== fib4_seq[c / 3 - 1]) begin
          failures++;
          $display("FAIL div3_sample cycle %0d out=%h required %h", c, if_d3.prng_out, fib4_seq[c / 3 - 1]);
        end
        $display("div3 cycle %0d out=%h", c, if_d3.prng_out);
      end
    end
    en = 1'b0;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    checks++;
    if (if_d3.out_valid !== 1'b1 || if_d3.prng_out !== 4'h3) begin
      failures++;
      $display("FAIL div3_step valid=%b out=%h required 1/3", if_d3.out_valid, if_d3.prng_out);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (if_d3.out_valid !== 1'b0 || if_d3.prng_out !== 4'h3) begin
        failures++;
        $display("FAIL div3_single cycle %0d valid=%b out=%h required 0/3",
                 c, if_d3.out_valid, if_d3.prng_out);
      end
    end
    $display("test_div3: done");
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    en = 1'b1;
    cyc();
    checks++;
    if (if_f4.prng_out !== 4'h2 || if_f4.out_valid !== 1'b1 || ov_f4 !== 1'b0) begin
      failures++;
      $display("FAIL bp_first out=%h valid=%b ov=%b required 2/1/0",
               if_f4.prng_out, if_f4.out_valid, ov_f4);
    end
    repeat (2) begin
      cyc();
      checks++;
      if (if_f4.prng_out !== 4'h2 || if_f4.out_valid !== 1'b1 || ov_f4 !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold out=%h valid=%b ov=%b required 2/1/1",
                 if_f4.prng_out, if_f4.out_valid, ov_f4);
      end
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (if_f4.prng_out !== 4'h4 || if_f4.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume out=%h valid=%b required 4/1", if_f4.prng_out, if_f4.out_valid);
    end
    // Drop and clear in the same cycle: the drop must keep overrun set.
    out_ready = 1'b0;
    clr_flags = 1'b1;
    cyc();
    checks++;
    if (ov_f4 !== 1'b1 || if_f4.prng_out !== 4'h4) begin
      failures++;
      $display("FAIL bp_set_wins ov=%b out=%h required 1/4", ov_f4, if_f4.prng_out);
    end
    out_ready = 1'b1;
    cyc();
    clr_flags = 1'b0;
    en = 1'b0;
    checks++;
    if (ov_f4 !== 1'b0 || if_f4.prng_out !== 4'h9) begin
      failures++;
      $display("FAIL bp_clear ov=%b out=%h required 0/9", ov_f4, if_f4.prng_out);
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_seed();
    apply_reset();
    seed_load = 1'b1;
    seed_in = 8'h00;
    cyc();
    seed_load = 1'b0;
    checks++;
    if (se_f4 !== 1'b1 || if_f4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL seed_zero_err se=%b valid=%b required 1/0", se_f4, if_f4.out_valid);
    end
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    checks++;
    if (if_f4.prng_out !== 4'h2 || if_f8.prng_out !== 8'h02) begin
      failures++;
      $display("FAIL seed_zero_subst out4=%h out8=%h required 2/02", if_f4.prng_out, if_f8.prng_out);
    end
    // Load coincides with a free-run tick: no sample that cycle.
    en = 1'b1;
    seed_load = 1'b1;
    seed_in = 8'hA5;
    cyc();
    seed_load = 1'b0;
    checks++;
    if (if_f8.out_valid !== 1'b0 || if_f8.prng_out !== 8'h02 || se_f8 !== 1'b1) begin
      failures++;
      $display("FAIL seed_load_nostep valid=%b out=%h se=%b required 0/02/1",
               if_f8.out_valid, if_f8.prng_out, se_f8);
    end
    cyc();
    en = 1'b0;
    checks++;
    if (if_f8.prng_out !== 8'h4A || if_f8.out_valid !== 1'b1 || if_f8.wrap !== 1'b0) begin
      failures++;
      $display("FAIL seed_next out=%h valid=%b wrap=%b required 4A/1/0",
               if_f8.prng_out, if_f8.out_valid, if_f8.wrap);
    end
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    checks++;
    if (se_f8 !== 1'b0) begin
      failures++;
      $display("FAIL seed_clr se=%b required 0", se_f8);
    end
    $display("test_seed: done");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fib4();
    test_gal4();
    test_fib8_period();
    test_div3();
    test_backpressure();
    test_seed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
